// File: rtl/hit_led_pkg.sv
// Shared definitions for the per-lane hit LED driver: lane state encoding,
// PWM width/duty limits and lane index constants.
package hit_led_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_FADE = 2'd2
    } lane_state_t;

    localparam int         PWM_W    = 8;
    localparam logic [7:0] DUTY_MAX = 8'd255;

    localparam int LANE_U = 0;
    localparam int LANE_L = 1;
    localparam int LANE_R = 2;
    localparam int LANE_D = 3;

endpackage

// File: rtl/hit_led_lane.sv
// One LED lane: solid HOLD after a hit, then a stepped PWM fade back to IDLE.
// Any hit restarts the HOLD phase, taking priority over the lane's own timing.
module hit_led_lane
    import hit_led_pkg::*;
#(
    parameter int HOLD_CYCLES      = 10_000_000,
    parameter int FADE_STEP_CYCLES = 39_062,
    parameter int FADE_DEC         = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_hit,
    input  logic [PWM_W-1:0] i_pwm_cnt,
    output logic             o_led,
    output logic             o_busy
);

    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam int SW = (FADE_STEP_CYCLES > 1) ? $clog2(FADE_STEP_CYCLES) : 1;

    localparam logic [HW-1:0]    HOLD_LAST = HW'(HOLD_CYCLES - 1);
    localparam logic [SW-1:0]    STEP_LAST = SW'(FADE_STEP_CYCLES - 1);
    localparam logic [PWM_W-1:0] DEC       = PWM_W'(FADE_DEC);

    lane_state_t      r_state, w_state_nxt;
    logic [HW-1:0]    r_hold_cnt, w_hold_nxt;
    logic [SW-1:0]    r_step_cnt, w_step_nxt;
    logic [PWM_W-1:0] r_duty, w_duty_nxt;
    logic             r_led, w_led_nxt;
    logic             r_busy, w_busy_nxt;

    // Floor-at-zero decrement; a zero result marks the end of the fade.
    function automatic logic [PWM_W-1:0] fade_dec(input logic [PWM_W-1:0] duty);
        return (duty <= DEC) ? '0 : duty - DEC;
    endfunction

    always_comb begin
        w_state_nxt = r_state;
        w_hold_nxt  = r_hold_cnt;
        w_step_nxt  = r_step_cnt;
        w_duty_nxt  = r_duty;
        if (i_hit) begin
            w_state_nxt = ST_HOLD;
            w_hold_nxt  = '0;
        end else begin
            case (r_state)
                ST_IDLE: ;
                ST_HOLD: begin
                    if (r_hold_cnt == HOLD_LAST) begin
                        w_state_nxt = ST_FADE;
                        w_duty_nxt  = DUTY_MAX;
                        w_step_nxt  = '0;
                    end else begin
                        w_hold_nxt = r_hold_cnt + 1'b1;
                    end
                end
                ST_FADE: begin
                    if (r_step_cnt == STEP_LAST) begin
                        w_step_nxt = '0;
                        w_duty_nxt = fade_dec(r_duty);
                        if (fade_dec(r_duty) == '0) begin
                            w_state_nxt = ST_IDLE;
                        end
                    end else begin
                        w_step_nxt = r_step_cnt + 1'b1;
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end

        // PWM compare uses the pre-edge counter, so led trails pwm_cnt by one cycle.
        case (w_state_nxt)
            ST_HOLD: w_led_nxt = 1'b1;
            ST_FADE: w_led_nxt = (i_pwm_cnt < w_duty_nxt);
            default: w_led_nxt = 1'b0;
        endcase
        w_busy_nxt = (w_state_nxt != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_hold_cnt <= '0;
            r_step_cnt <= '0;
            r_duty     <= '0;
            r_led      <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_hold_cnt <= w_hold_nxt;
            r_step_cnt <= w_step_nxt;
            r_duty     <= w_duty_nxt;
            r_led      <= w_led_nxt;
            r_busy     <= w_busy_nxt;
        end
    end

    assign o_led  = r_led;
    assign o_busy = r_busy;

endmodule

// File: rtl/hit_led_driver.sv
// LED feedback driver for the play buttons: one shared free-running PWM
// counter feeding LANES independent hold-then-fade lanes.
module hit_led_driver
    import hit_led_pkg::*;
#(
    parameter int LANES            = 4,
    parameter int HOLD_CYCLES      = 10_000_000,
    parameter int FADE_STEP_CYCLES = 39_062,
    parameter int FADE_DEC         = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [LANES-1:0] hit,
    output logic [LANES-1:0] led,
    output logic [LANES-1:0] busy
);

    logic [PWM_W-1:0] r_pwm_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pwm_cnt <= '0;
        end else begin
            r_pwm_cnt <= r_pwm_cnt + 1'b1;
        end
    end

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        hit_led_lane #(
            .HOLD_CYCLES     (HOLD_CYCLES),
            .FADE_STEP_CYCLES(FADE_STEP_CYCLES),
            .FADE_DEC        (FADE_DEC)
        ) u_lane (
            .clk      (clk),
            .rst      (rst),
            .i_hit    (hit[g]),
            .i_pwm_cnt(r_pwm_cnt),
            .o_led    (led[g]),
            .o_busy   (busy[g])
        );
    end

endmodule

// File: tb/tb_hit_led_driver.sv
// Scoreboard bench: a time-since-hit lane model predicts led/busy per cycle;
// a second instance with long fade steps checks PWM duty by counting.
module tb_hit_led_driver;

    localparam int H_A   = 4;
    localparam int S_A   = 2;
    localparam int DEC_A = 64;
    localparam int TOT_A = H_A + ((255 + DEC_A - 1) / DEC_A) * S_A;

    localparam int H_B   = 4;
    localparam int S_B   = 512;
    localparam int DEC_B = 128;
    localparam int TOT_B = H_B + ((255 + DEC_B - 1) / DEC_B) * S_B;

    logic       clk;
    logic       rst;
    logic [3:0] hit_a, hit_b;
    logic [3:0] led_a, busy_a, led_b, busy_b;

    int checks = 0;
    int errors = 0;
    string phase = "init";

    int m_t [4];
    int m_pwm;
    logic [7:0] q_exp [$];

    hit_led_driver #(
        .LANES(4), .HOLD_CYCLES(H_A), .FADE_STEP_CYCLES(S_A), .FADE_DEC(DEC_A)
    ) dut (
        .clk(clk), .rst(rst), .hit(hit_a), .led(led_a), .busy(busy_a)
    );

    hit_led_driver #(
        .LANES(4), .HOLD_CYCLES(H_B), .FADE_STEP_CYCLES(S_B), .FADE_DEC(DEC_B)
    ) dut_pwm (
        .clk(clk), .rst(rst), .hit(hit_b), .led(led_b), .busy(busy_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    // {led, busy} for a lane t cycles after its last hit edge; pwm is the pre-edge counter.
    function automatic logic [1:0] exp_lane(input int t, input int pwm,
                                            input int h, input int s, input int dec);
        int n, total, duty;
        n     = (255 + dec - 1) / dec;
        total = h + n * s;
        if (t >= total) return 2'b00;
        if (t < h) return 2'b11;
        duty = 255 - ((t - h) / s) * dec;
        return {(pwm < duty), 1'b1};
    endfunction

    task automatic cyc(input logic [3:0] h, input logic r);
        logic [7:0] e;
        logic [1:0] lb;
        int pb;
        hit_a = h;
        rst   = r;
        pb    = m_pwm;
        e     = '0;
        if (r) begin
            for (int i = 0; i < 4; i++) m_t[i] = TOT_A;
            m_pwm = 0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (h[i]) m_t[i] = 0;
                else if (m_t[i] < TOT_A) m_t[i]++;
            end
            m_pwm = (m_pwm + 1) % 256;
            for (int i = 0; i < 4; i++) begin
                lb       = exp_lane(m_t[i], pb, H_A, S_A, DEC_A);
                e[4 + i] = lb[1];
                e[i]     = lb[0];
            end
        end
        q_exp.push_back(e);
        @(posedge clk);
        #1;
        check_eq(phase, {24'd0, led_a, busy_a}, {24'd0, q_exp.pop_front()});
    endtask

    initial begin
        int cnt, cnt255, cnt127;
        hit_a = '0;
        hit_b = '0;
        rst   = 1'b1;
        m_pwm = 0;
        for (int i = 0; i < 4; i++) m_t[i] = TOT_A;

        phase = "reset";
        cyc(4'b0000, 1'b1);
        cyc(4'b0000, 1'b1);
        check_eq("rst_led_b", {28'd0, led_b}, 32'd0);
        check_eq("rst_busy_b", {28'd0, busy_b}, 32'd0);
        check_eq("rst_pwm", {24'd0, dut.r_pwm_cnt}, 32'd0);
        phase = "idle";
        repeat (3) cyc(4'b0000, 1'b0);

        phase = "single";
        cnt = 0;
        cyc(4'b0001, 1'b0);
        cnt += busy_a[0];
        repeat (15) begin
            cyc(4'b0000, 1'b0);
            cnt += busy_a[0];
        end
        check_eq("busy0_len", cnt, 12);

        phase = "retrig";
        cnt = 0;
        cyc(4'b0100, 1'b0);
        cnt += busy_a[2];
        repeat (5) begin
            cyc(4'b0000, 1'b0);
            cnt += busy_a[2];
        end
        cyc(4'b0100, 1'b0);
        cnt += busy_a[2];
        repeat (16) begin
            cyc(4'b0000, 1'b0);
            cnt += busy_a[2];
        end
        check_eq("busy2_len", cnt, 18);

        phase = "simul";
        cyc(4'b1010, 1'b0);
        repeat (14) cyc(4'b0000, 1'b0);

        phase = "rst_fade";
        cyc(4'b0001, 1'b0);
        repeat (6) cyc(4'b0000, 1'b0);
        cyc(4'b0001, 1'b1);
        check_eq("rst_fade_pwm", {24'd0, dut.r_pwm_cnt}, 32'd0);
        repeat (4) cyc(4'b0000, 1'b0);

        phase = "held";
        repeat (10) cyc(4'b0001, 1'b0);
        repeat (16) cyc(4'b0000, 1'b0);

        phase = "random";
        for (int k = 0; k < 300; k++) begin
            logic [3:0] hr;
            hr = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(1, 15)) : 4'b0000;
            cyc(hr, ($urandom_range(0, 149) == 0));
        end
        repeat (TOT_A + 2) cyc(4'b0000, 1'b0);

        phase = "pwm";
        cnt    = 0;
        cnt255 = 0;
        cnt127 = 0;
        hit_b  = 4'b0001;
        cyc(4'b0000, 1'b0);
        hit_b  = 4'b0000;
        cnt += busy_b[0];
        for (int k = 1; k <= TOT_B + 20; k++) begin
            cyc(4'b0000, 1'b0);
            cnt += busy_b[0];
            if (k >= H_B + 10 && k < H_B + 10 + 256) cnt255 += led_b[0];
            if (k >= H_B + S_B + 10 && k < H_B + S_B + 10 + 256) cnt127 += led_b[0];
        end
        check_eq("pwm_duty255", cnt255, 255);
        check_eq("pwm_duty127", cnt127, 127);
        check_eq("pwm_busy_len", cnt, TOT_B);
        check_eq("pwm_other_lanes", {28'd0, busy_b[3:1]}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
